// File: rtl/vx_tag_pkg.sv
// Shared types and geometry helpers for the vx_tag_assoc tag store.
// Built with TAG_PERF_CNT_EN defined, the top also carries hit/miss counters.
package vx_tag_pkg;

   // Tags are stored zero-extended to a fixed width so one entry type serves every geometry.
   localparam int TAG_MAX_BITS = 32;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } tag_state_e;

   typedef struct packed {
      logic                    reserved;
      logic                    valid;
      logic [TAG_MAX_BITS-1:0] tag;
   } tag_entry_t;

   function automatic int calc_sets(input int cache_size, input int line_size,
                                    input int num_banks, input int num_ways);
      return cache_size / (line_size * num_banks * num_ways);
   endfunction

   function automatic int calc_set_bits(input int sets);
      return (sets > 1) ? $clog2(sets) : 1;
   endfunction

   function automatic int calc_line_addr_width(input int line_size, input int num_banks);
      return 32 - $clog2(line_size) - $clog2(num_banks);
   endfunction

   function automatic int calc_tag_bits(input int line_addr_width, input int set_bits);
      return line_addr_width - set_bits;
   endfunction

   function automatic int calc_way_bits(input int num_ways);
      return (num_ways > 1) ? $clog2(num_ways) : 1;
   endfunction

endpackage

// File: rtl/vx_tag_assoc_if.sv
// Request/response bundle between the bank pipeline (master) and the tag store (slave).
interface vx_tag_assoc_if #(
   parameter int ADDR_W = 24,
   parameter int WAYS   = 4
);
   logic              stall;
   logic              lookup;
   logic [ADDR_W-1:0] addr;
   logic              fill;
   logic              flush;
   logic              flush_all;
   logic              should_reserve;
   logic              tag_match;
   logic [WAYS-1:0]   hit_way;
   logic              reserved;
   logic [WAYS-1:0]   victim_way;
   logic              ready;

   modport master (
      output stall, lookup, addr, fill, flush, flush_all, should_reserve,
      input  tag_match, hit_way, reserved, victim_way, ready
   );

   modport slave (
      input  stall, lookup, addr, fill, flush, flush_all, should_reserve,
      output tag_match, hit_way, reserved, victim_way, ready
   );
endinterface

// File: rtl/vx_tag_way.sv
// One way of the tag store: SETS-deep entry array with combinational read and tag compare.
module vx_tag_way
   import vx_tag_pkg::*;
#(
   parameter int SETS     = 64,
   parameter int SET_BITS = 6
) (
   input  logic                    clk,
   input  logic [SET_BITS-1:0]     rd_set,
   input  logic [TAG_MAX_BITS-1:0] rd_tag,
   input  logic [SET_BITS-1:0]     wr_set,
   input  logic                    wr_en,
   input  logic                    clr,
   input  tag_entry_t              wr_entry,
   output logic                    rd_valid,
   output logic                    rd_reserved,
   output logic                    match
);
   tag_entry_t entry_mem [SETS];
   tag_entry_t rd_entry;

   // Clear wins over write so the init walk and flushes cannot be overridden by a fill.
   always_ff @(posedge clk) begin
      if (clr) begin
         entry_mem[wr_set] <= '0;
      end else if (wr_en) begin
         entry_mem[wr_set] <= wr_entry;
      end
   end

   assign rd_entry    = entry_mem[rd_set];
   assign rd_valid    = rd_entry.valid;
   assign rd_reserved = rd_entry.reserved;
   assign match       = rd_entry.valid && (rd_entry.tag == rd_tag);
endmodule

// File: rtl/vx_tag_assoc.sv
// Set-associative tag store for one cache bank: lookup, victim choice, fill/flush, init walk.
// Optional TAG_PERF_CNT_EN adds saturating perf_hits / perf_misses outputs.
module vx_tag_assoc
   import vx_tag_pkg::*;
#(
   parameter int CACHE_ID         = 0,
   parameter int BANK_ID          = 0,
   parameter int CACHE_SIZE       = 16384,
   parameter int CACHE_LINE_SIZE  = 64,
   parameter int NUM_BANKS        = 4,
   parameter int NUM_WAYS         = 4,
   parameter int WORD_SIZE        = 4,
   parameter int BANK_ADDR_OFFSET = 0
) (
   input  logic          clk,
   input  logic          reset,
   vx_tag_assoc_if.slave bus
`ifdef TAG_PERF_CNT_EN
   ,
   output logic [31:0]   perf_hits,
   output logic [31:0]   perf_misses
`endif
);
   localparam int SETS            = calc_sets(CACHE_SIZE, CACHE_LINE_SIZE, NUM_BANKS, NUM_WAYS);
   localparam int SET_BITS        = calc_set_bits(SETS);
   localparam int LINE_ADDR_WIDTH = calc_line_addr_width(CACHE_LINE_SIZE, NUM_BANKS);
   localparam int TAG_BITS        = calc_tag_bits(LINE_ADDR_WIDTH, SET_BITS);
   localparam int WAY_BITS        = calc_way_bits(NUM_WAYS);

   if (NUM_WAYS < 1 || NUM_WAYS > 8 || (NUM_WAYS & (NUM_WAYS - 1)) != 0) begin : g_bad_ways
      $error("vx_tag_assoc: NUM_WAYS must be a power of two in 1..8");
   end
   if (SETS < 2 || (CACHE_LINE_SIZE % WORD_SIZE) != 0 || BANK_ADDR_OFFSET < 0) begin : g_bad_geom
      $error("vx_tag_assoc: unsupported cache geometry");
   end

   tag_state_e              state_reg;
   logic [SET_BITS-1:0]     init_cnt_reg;
   logic [SET_BITS-1:0]     set_idx;
   logic [SET_BITS-1:0]     wr_set;
   logic [TAG_BITS-1:0]     tag_in;
   logic [TAG_MAX_BITS-1:0] tag_ext;
   logic                    is_ready;
   logic                    do_fill;
   logic                    do_flush;
   logic                    from_ptr;
   logic [NUM_WAYS-1:0]     way_match;
   logic [NUM_WAYS-1:0]     way_valid;
   logic [NUM_WAYS-1:0]     way_resv;
   logic [NUM_WAYS-1:0]     invalid_vec;
   logic [NUM_WAYS-1:0]     victim_vec;
   logic [NUM_WAYS-1:0]     ptr_onehot;
   tag_entry_t              wr_entry;

   assign set_idx  = bus.addr[SET_BITS-1:0];
   assign tag_in   = bus.addr[LINE_ADDR_WIDTH-1:SET_BITS];
   assign tag_ext  = TAG_MAX_BITS'(tag_in);
   assign is_ready = (state_reg == READY);
   assign wr_set   = is_ready ? set_idx : init_cnt_reg;
   assign do_flush = is_ready && !bus.stall && bus.flush;
   assign do_fill  = is_ready && !bus.stall && bus.fill && !bus.flush;
   assign wr_entry = '{reserved: bus.should_reserve, valid: 1'b1, tag: tag_ext};

   for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
      logic way_we;
      logic way_clr;
      assign way_we  = do_fill && victim_vec[gi];
      assign way_clr = !is_ready || (do_flush && way_match[gi]);

      vx_tag_way #(
         .SETS     (SETS),
         .SET_BITS (SET_BITS)
      ) u_way (
         .clk         (clk),
         .rd_set      (set_idx),
         .rd_tag      (tag_ext),
         .wr_set      (wr_set),
         .wr_en       (way_we),
         .clr         (way_clr),
         .wr_entry    (wr_entry),
         .rd_valid    (way_valid[gi]),
         .rd_reserved (way_resv[gi]),
         .match       (way_match[gi])
      );
   end

   // Lowest invalid way first; only a full set falls back to the round-robin pointer.
   assign invalid_vec = ~way_valid;
   assign from_ptr    = ~|invalid_vec;
   assign victim_vec  = from_ptr ? ptr_onehot
                                 : (invalid_vec & (~invalid_vec + NUM_WAYS'(1)));

   if (NUM_WAYS > 1) begin : g_ptr
      logic [WAY_BITS-1:0] ptr_mem [SETS];
      logic [WAY_BITS-1:0] ptr_cur;
      assign ptr_cur    = ptr_mem[set_idx];
      assign ptr_onehot = NUM_WAYS'(1) << ptr_cur;

      always_ff @(posedge clk) begin
         if (!is_ready) begin
            ptr_mem[init_cnt_reg] <= '0;
         end else if (do_fill && from_ptr) begin
            ptr_mem[set_idx] <= ptr_cur + WAY_BITS'(1);
         end
      end
   end else begin : g_noptr
      assign ptr_onehot = NUM_WAYS'(1);
   end

   // The walk ignores stall; flush_all restarts it from set 0 in either state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg    <= INIT;
         init_cnt_reg <= '0;
      end else begin
         case (state_reg)
            INIT: begin
               if (bus.flush_all) begin
                  init_cnt_reg <= '0;
               end else if (init_cnt_reg == SET_BITS'(SETS - 1)) begin
                  state_reg    <= READY;
                  init_cnt_reg <= '0;
               end else begin
                  init_cnt_reg <= init_cnt_reg + SET_BITS'(1);
               end
            end
            default: begin
               if (bus.flush_all) begin
                  state_reg    <= INIT;
                  init_cnt_reg <= '0;
               end
            end
         endcase
      end
   end

   assign bus.tag_match  = is_ready && (|way_match);
   assign bus.hit_way    = is_ready ? way_match : '0;
   assign bus.reserved   = is_ready && (|(way_match & way_resv));
   assign bus.victim_way = is_ready ? victim_vec : NUM_WAYS'(1);
   assign bus.ready      = is_ready;

`ifdef TAG_PERF_CNT_EN
   logic [31:0] perf_hits_reg;
   logic [31:0] perf_misses_reg;

   always_ff @(posedge clk) begin
      if (!reset) begin
         perf_hits_reg   <= '0;
         perf_misses_reg <= '0;
      end else if (bus.lookup && is_ready && !bus.stall) begin
         if (|way_match) begin
            if (perf_hits_reg != '1) perf_hits_reg <= perf_hits_reg + 32'd1;
         end else begin
            if (perf_misses_reg != '1) perf_misses_reg <= perf_misses_reg + 32'd1;
         end
      end
   end

   assign perf_hits   = perf_hits_reg;
   assign perf_misses = perf_misses_reg;
`endif

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (reset && is_ready) begin
         if (bus.fill && bus.flush && !bus.stall) begin
            $warning("vx_tag_assoc[%0d.%0d]: fill and flush together on set %0d, fill dropped",
                     CACHE_ID, BANK_ID, set_idx);
         end
         if (bus.lookup || bus.fill || bus.flush) begin
            assert ($onehot0(way_match))
            else $error("vx_tag_assoc[%0d.%0d]: multiple ways hit in set %0d",
                        CACHE_ID, BANK_ID, set_idx);
         end
      end
   end
`endif
endmodule

// File: tb/tb_vx_tag_assoc.sv
// Directed bench for vx_tag_assoc: 4 ways, 64 sets (CACHE_SIZE overridden to 65536).
module tb_vx_tag_assoc;
   localparam int ADDR_W = 24;
   localparam int WAYS   = 4;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   vx_tag_assoc_if #(.ADDR_W(ADDR_W), .WAYS(WAYS)) bus ();

`ifdef TAG_PERF_CNT_EN
   logic [31:0] perf_hits;
   logic [31:0] perf_misses;
`endif

   vx_tag_assoc #(
      .CACHE_SIZE (65536),
      .NUM_WAYS   (WAYS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus)
`ifdef TAG_PERF_CNT_EN
      ,
      .perf_hits   (perf_hits),
      .perf_misses (perf_misses)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [ADDR_W-1:0] mk(input logic [17:0] tag, input logic [5:0] set);
      return {tag, set};
   endfunction

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_op(input string name, input logic [17:0] tag, input logic [5:0] set,
                          input logic res, input logic [3:0] exp_victim);
      bus.addr           = mk(tag, set);
      bus.fill           = 1'b1;
      bus.should_reserve = res;
      #1;
      $display("fill   %-14s set=%0d tag=%0h victim=%b", name, set, tag, bus.victim_way);
      check({name, "_victim"}, 32'(bus.victim_way), 32'(exp_victim));
      tick();
      bus.fill           = 1'b0;
      bus.should_reserve = 1'b0;
   endtask

   task automatic look(input string name, input logic [17:0] tag, input logic [5:0] set,
                       input logic exp_tm, input logic [3:0] exp_hw, input logic exp_res,
                       input logic [3:0] exp_victim);
      bus.addr   = mk(tag, set);
      bus.lookup = 1'b1;
      #1;
      $display("lookup %-14s set=%0d tag=%0h match=%b way=%b res=%b victim=%b",
               name, set, tag, bus.tag_match, bus.hit_way, bus.reserved, bus.victim_way);
      check({name, "_match"},  32'(bus.tag_match),  32'(exp_tm));
      check({name, "_hitway"}, 32'(bus.hit_way),    32'(exp_hw));
      check({name, "_resv"},   32'(bus.reserved),   32'(exp_res));
      check({name, "_victim"}, 32'(bus.victim_way), 32'(exp_victim));
      tick();
      bus.lookup = 1'b0;
   endtask

   task automatic flush_op(input string name, input logic [17:0] tag, input logic [5:0] set);
      bus.addr  = mk(tag, set);
      bus.flush = 1'b1;
      $display("flush  %-14s set=%0d tag=%0h", name, set, tag);
      tick();
      bus.flush = 1'b0;
   endtask

   task automatic pulse_flush_all();
      bus.flush_all = 1'b1;
      $display("flush_all");
      tick();
      bus.flush_all = 1'b0;
   endtask

   task automatic wait_ready(input string name, input int exp_cycles);
      int n = 0;
      while (!bus.ready && n < 1000) begin
         tick();
         n++;
      end
      $display("walk   %-14s ready after %0d cycles", name, n);
      check(name, 32'(n), 32'(exp_cycles));
   endtask

   initial begin
      checks             = 0;
      errors             = 0;
      reset              = 1'b0;
      bus.stall          = 1'b0;
      bus.lookup         = 1'b0;
      bus.addr           = '0;
      bus.fill           = 1'b0;
      bus.flush          = 1'b0;
      bus.flush_all      = 1'b0;
      bus.should_reserve = 1'b0;

      // Reset state
      tick(); tick(); tick();
      check("rst_tag_match", 32'(bus.tag_match),  32'd0);
      check("rst_hit_way",   32'(bus.hit_way),    32'd0);
      check("rst_reserved",  32'(bus.reserved),   32'd0);
      check("rst_victim",    32'(bus.victim_way), 32'd1);
      check("rst_ready",     32'(bus.ready),      32'd0);
      reset = 1'b1;
      wait_ready("init_walk", 64);

      // Round-robin in set 5
      fill_op("s5_f11", 18'h11, 6'd5, 1'b0, 4'b0001);
      fill_op("s5_f12", 18'h12, 6'd5, 1'b0, 4'b0010);
      fill_op("s5_f13", 18'h13, 6'd5, 1'b0, 4'b0100);
      fill_op("s5_f14", 18'h14, 6'd5, 1'b0, 4'b1000);
      fill_op("s5_f15", 18'h15, 6'd5, 1'b0, 4'b0001);
      fill_op("s5_f16", 18'h16, 6'd5, 1'b0, 4'b0010);
      look("s5_l11", 18'h11, 6'd5, 1'b0, 4'b0000, 1'b0, 4'b0100);
      look("s5_l12", 18'h12, 6'd5, 1'b0, 4'b0000, 1'b0, 4'b0100);
      look("s5_l13", 18'h13, 6'd5, 1'b1, 4'b0100, 1'b0, 4'b0100);
      look("s5_l14", 18'h14, 6'd5, 1'b1, 4'b1000, 1'b0, 4'b0100);
      look("s5_l15", 18'h15, 6'd5, 1'b1, 4'b0001, 1'b0, 4'b0100);
      look("s5_l16", 18'h16, 6'd5, 1'b1, 4'b0010, 1'b0, 4'b0100);

      // Reserved fill then flush in set 9
      fill_op("s9_f3a", 18'h3A, 6'd9, 1'b1, 4'b0001);
      look("s9_l3a", 18'h3A, 6'd9, 1'b1, 4'b0001, 1'b1, 4'b0010);
      flush_op("s9_fl3a", 18'h3A, 6'd9);
      look("s9_l3a_post", 18'h3A, 6'd9, 1'b0, 4'b0000, 1'b0, 4'b0001);

      // fill+flush together on a hit in full set 5 (pointer at way 2): flush wins
      bus.addr  = mk(18'h13, 6'd5);
      bus.fill  = 1'b1;
      bus.flush = 1'b1;
      #1;
      $display("fill+flush set=5 tag=13 hit_way=%b", bus.hit_way);
      check("ff_pre_hitway", 32'(bus.hit_way), 32'b0100);
      tick();
      bus.fill  = 1'b0;
      bus.flush = 1'b0;
      look("ff_l13", 18'h13, 6'd5, 1'b0, 4'b0000, 1'b0, 4'b0100);
      fill_op("ff_f17", 18'h17, 6'd5, 1'b0, 4'b0100);
      look("ff_ptr", 18'h17, 6'd5, 1'b1, 4'b0100, 1'b0, 4'b0100);

      // Stalled fill must not land; the same fill afterwards hits the same victim
      bus.stall = 1'b1;
      fill_op("st_f18", 18'h18, 6'd5, 1'b0, 4'b0100);
      bus.stall = 1'b0;
      look("st_l18", 18'h18, 6'd5, 1'b0, 4'b0000, 1'b0, 4'b0100);
      look("st_l17", 18'h17, 6'd5, 1'b1, 4'b0100, 1'b0, 4'b0100);
      fill_op("st_f18b", 18'h18, 6'd5, 1'b0, 4'b0100);
      look("st_l18b", 18'h18, 6'd5, 1'b1, 4'b0100, 1'b0, 4'b1000);

      // flush_all from READY; lookups during the walk are forced to miss
      pulse_flush_all();
      bus.addr   = mk(18'h18, 6'd5);
      bus.lookup = 1'b1;
      #1;
      check("walk_tag_match", 32'(bus.tag_match), 32'd0);
      check("walk_hit_way",   32'(bus.hit_way),   32'd0);
      bus.lookup = 1'b0;
      wait_ready("fa_walk", 64);
      look("fa_l18", 18'h18, 6'd5, 1'b0, 4'b0000, 1'b0, 4'b0001);
      look("fa_l15", 18'h15, 6'd5, 1'b0, 4'b0000, 1'b0, 4'b0001);

      // flush_all while already walking restarts at set 0
      fill_op("r1_f20", 18'h20, 6'd7, 1'b0, 4'b0001);
      pulse_flush_all();
      for (int i = 0; i < 20; i++) tick();
      check("fa_mid_ready", 32'(bus.ready), 32'd0);
      pulse_flush_all();
      wait_ready("fa_restart", 64);
      look("r1_l20", 18'h20, 6'd7, 1'b0, 4'b0000, 1'b0, 4'b0001);

      // Reset at walk cycle 30 restarts the walk
      fill_op("r2_f21", 18'h21, 6'd7, 1'b0, 4'b0001);
      pulse_flush_all();
      for (int i = 0; i < 30; i++) tick();
      reset = 1'b0;
      tick();
      check("rst2_victim", 32'(bus.victim_way), 32'd1);
      check("rst2_ready",  32'(bus.ready),      32'd0);
      reset = 1'b1;
      wait_ready("rst_restart", 64);
      look("r2_l21", 18'h21, 6'd7, 1'b0, 4'b0000, 1'b0, 4'b0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
